// File: rtl/moonbase_bus_bridge.sv
// External-bus model for the moonbase CPU: address latch, split code/data nibble SRAM,
// 2-bit device input / 4-bit device output port, and a nibble loader that owns the CPU reset.
module moonbase_bus_bridge #(
    parameter int RELEASE_CYCLES = 2,
    parameter bit SPLIT_SPACES   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_out,
    output logic [5:0] cpu_in_hi,
    output logic       cpu_reset,
    input  logic       load_mode,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic [7:0] load_count,
    output logic [6:0] dev_addr,
    output logic       dev_nib,
    output logic [3:0] dev_wdata,
    output logic       dev_we,
    input  logic [1:0] dev_rdata
);
    typedef enum logic [1:0] {ST_RELEASE, ST_RUN, ST_LOAD} state_t;

    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       latch_q, latch_d;
    logic             nib_q, nib_d;
    logic [7:0]       load_count_q, load_count_d;

    logic [3:0] sram [512];
    logic       bus_strobe;
    logic       bus_space;
    logic [8:0] bus_index;
    logic       ram_we;
    logic [8:0] ram_waddr;
    logic [3:0] ram_wdata;

    assign bus_strobe = cpu_out[7];
    assign bus_space  = SPLIT_SPACES ? cpu_out[6] : 1'b1;
    assign bus_index  = {bus_space, latch_q, nib_q};

    // NOTE: flops take only non-blocking assignments; all next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RELEASE;
            cnt_q        <= '0;
            latch_q      <= '0;
            nib_q        <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            nib_q        <= nib_d;
            load_count_q <= load_count_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        state_d      = state_q;
        cnt_d        = '0;
        latch_d      = latch_q;
        nib_d        = nib_q;
        load_count_d = load_count_q;
        case (state_q)
            ST_RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (load_mode) begin
                        state_d      = ST_LOAD;
                        load_count_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus_strobe) begin
                    latch_d = cpu_out[6:0];
                    nib_d   = 1'b0;
                end else begin
                    nib_d = ~nib_q;
                end
                // The cycle in which load_mode rises still decodes normally.
                if (load_mode) begin
                    state_d      = ST_LOAD;
                    load_count_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) load_count_d = load_count_q + 8'd1;
                if (!load_mode) state_d = ST_RELEASE;
            end
            default: state_d = ST_RELEASE;
        endcase
    end

    always_comb begin
        cpu_reset  = 1'b1;
        load_ready = 1'b0;
        dev_we     = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = bus_index;
        ram_wdata  = cpu_out[3:0];
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    cpu_reset = 1'b0;
                    dev_we    = !bus_strobe && !cpu_out[4];
                    ram_we    = !bus_strobe && !cpu_out[5];
                end
                ST_LOAD: begin
                    // Loader indexes code space directly; the CPU is held in reset meanwhile.
                    load_ready = 1'b1;
                    ram_we     = load_valid;
                    ram_waddr  = {1'b1, load_count_q};
                    ram_wdata  = load_data;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the SRAM array is intentionally left unreset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (ram_we) sram[ram_waddr] <= ram_wdata;
    end

    assign cpu_in_hi  = {dev_rdata, sram[bus_index]};
    assign dev_addr   = latch_q;
    assign dev_nib    = nib_q;
    assign dev_wdata  = cpu_out[3:0];
    assign load_count = load_count_q;

endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// Directed bench for moonbase_bus_bridge: reset/release timing, loader, bus decode table,
// counter wrap and reset during a load.
module tb_moonbase_bus_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_out;
    logic [5:0] cpu_in_hi;
    logic       cpu_reset;
    logic       load_mode;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic [7:0] load_count;
    logic [6:0] dev_addr;
    logic       dev_nib;
    logic [3:0] dev_wdata;
    logic       dev_we;
    logic [1:0] dev_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] cpu_out;
        logic [1:0] dev_rdata;
        bit         chk;
        logic [5:0] in_mask;
        logic [5:0] exp_in;
        logic       exp_we;
        logic [6:0] exp_addr;
        logic       exp_nib;
        logic [3:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    moonbase_bus_bridge #(.RELEASE_CYCLES(2), .SPLIT_SPACES(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_out    (cpu_out),
        .cpu_in_hi  (cpu_in_hi),
        .cpu_reset  (cpu_reset),
        .load_mode  (load_mode),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_count (load_count),
        .dev_addr   (dev_addr),
        .dev_nib    (dev_nib),
        .dev_wdata  (dev_wdata),
        .dev_we     (dev_we),
        .dev_rdata  (dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && load_ready !== 1'b1; i++) step();
        check(name, 32'(load_ready), 32'd1);
    endtask

    task automatic wait_run(input string name);
        for (int i = 0; i < 20 && cpu_reset !== 1'b0; i++) step();
        check(name, 32'(cpu_reset), 32'd0);
    endtask

    task automatic feed(input logic [3:0] d, input int gap);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
    endtask

    function automatic logic [3:0] wrap_pattern(input int i);
        logic [3:0] v;
        v = (i < 256) ? (4'(i) ^ 4'h5) : 4'hE;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;

        // Bus vectors: cpu_out, dev_rdata, chk, in_mask, exp_in, exp_we, exp_addr, exp_nib, exp_wdata
        vecs.push_back('{8'h80, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h70, 2'b00, 1'b1, 6'h3F, 6'h03, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h70, 2'b00, 1'b1, 6'h3F, 6'h0A, 1'b0, 7'h00, 1'b1, 4'h0});
        vecs.push_back('{8'h80, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h70, 2'b00, 1'b1, 6'h3F, 6'h03, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h85, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h17, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h18, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h85, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h30, 2'b00, 1'b1, 6'h3F, 6'h07, 1'b0, 7'h05, 1'b0, 4'h0});
        vecs.push_back('{8'h30, 2'b00, 1'b1, 6'h3F, 6'h08, 1'b0, 7'h05, 1'b1, 4'h0});
        vecs.push_back('{8'h30, 2'b00, 1'b1, 6'h3F, 6'h07, 1'b0, 7'h05, 1'b0, 4'h0});
        vecs.push_back('{8'h85, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h70, 2'b00, 1'b1, 6'h3F, 6'h0F, 1'b0, 7'h05, 1'b0, 4'h0});
        vecs.push_back('{8'h70, 2'b00, 1'b1, 6'h3F, 6'h0E, 1'b0, 7'h05, 1'b1, 4'h0});
        vecs.push_back('{8'h92, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h29, 2'b10, 1'b1, 6'h30, 6'h20, 1'b1, 7'h12, 1'b0, 4'h9});
        vecs.push_back('{8'h30, 2'b01, 1'b1, 6'h30, 6'h10, 1'b0, 7'h12, 1'b1, 4'h0});
        vecs.push_back('{8'h85, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h0B, 2'b00, 1'b1, 6'h3F, 6'h07, 1'b1, 7'h05, 1'b0, 4'hB});
        vecs.push_back('{8'h85, 2'b00, 1'b0, 6'h00, 6'h00, 1'b0, 7'h00, 1'b0, 4'h0});
        vecs.push_back('{8'h30, 2'b00, 1'b1, 6'h3F, 6'h0B, 1'b0, 7'h05, 1'b0, 4'h0});
        vecs.push_back('{8'h30, 2'b00, 1'b1, 6'h3F, 6'h08, 1'b0, 7'h05, 1'b1, 4'h0});

        // Reset for one cycle, then count how long cpu_reset stays high.
        reset      = 1'b1;
        cpu_out    = 8'h80;
        load_mode  = 1'b0;
        load_valid = 1'b0;
        load_data  = 4'h0;
        dev_rdata  = 2'b00;
        #1;
        check("rst cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst load_ready", 32'(load_ready), 32'd0);
        check("rst dev_we", 32'(dev_we), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rst dev_addr", 32'(dev_addr), 32'd0);
        check("rst dev_nib", 32'(dev_nib), 32'd0);
        check("rst load_count", 32'(load_count), 32'd0);
        check("release load_ready", 32'(load_ready), 32'd0);
        hi = 1;
        for (int i = 0; i < 10 && cpu_reset === 1'b1; i++) begin
            hi++;
            step();
        end
        check("release length", 32'(hi), 32'd3);

        // 257-nibble load: counter wraps and nibble 0 is overwritten.
        load_mode = 1'b1;
        step();
        wait_ready("wrap load_ready");
        cpu_out = 8'h00;
        #1;
        check("load dev_we gated", 32'(dev_we), 32'd0);
        check("load cpu_reset", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 257; i++) begin
            load_valid = 1'b1;
            load_data  = wrap_pattern(i);
            step();
            if (i == 255) check("wrap count 256", 32'(load_count), 32'd0);
        end
        load_valid = 1'b0;
        #1;
        check("wrap count 257", 32'(load_count), 32'd1);
        cpu_out   = 8'h80;
        load_mode = 1'b0;
        step();
        check("exit cpu_reset", 32'(cpu_reset), 32'd1);
        check("exit load_ready", 32'(load_ready), 32'd0);
        wait_run("wrap run");
        step();
        cpu_out = 8'h70;
        #1;
        check("wrap code0", 32'(cpu_in_hi[3:0]), 32'hE);
        step();
        check("wrap code1", 32'(cpu_in_hi[3:0]), 32'h4);

        // Load 3,A,5,C with gaps; load_mode rises in a decoding strobe cycle.
        cpu_out   = 8'h85;
        load_mode = 1'b1;
        #1;
        check("rise cycle run", 32'(cpu_reset), 32'd0);
        step();
        check("rise cycle decoded", 32'(dev_addr), 32'h05);
        check("load entry count", 32'(load_count), 32'd0);
        check("load entry ready", 32'(load_ready), 32'd1);
        cpu_out = 8'h80;
        feed(4'h3, 1);
        feed(4'hA, 0);
        feed(4'h5, 2);
        feed(4'hC, 0);
        check("load count 4", 32'(load_count), 32'd4);
        load_mode = 1'b0;
        step();
        wait_run("table run");

        foreach (vecs[i]) begin
            cpu_out   = vecs[i].cpu_out;
            dev_rdata = vecs[i].dev_rdata;
            #1;
            check($sformatf("v%0d dev_we", i), 32'(dev_we), 32'(vecs[i].exp_we));
            if (vecs[i].chk) begin
                check($sformatf("v%0d cpu_in_hi", i), 32'(cpu_in_hi & vecs[i].in_mask),
                      32'(vecs[i].exp_in));
                check($sformatf("v%0d dev_addr", i), 32'(dev_addr), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d dev_nib", i), 32'(dev_nib), 32'(vecs[i].exp_nib));
                check($sformatf("v%0d dev_wdata", i), 32'(dev_wdata), 32'(vecs[i].exp_wdata));
            end
            step();
        end
        dev_rdata = 2'b00;

        // Reset during a load, then reload from index 0 with a final nibble on load_mode fall.
        cpu_out   = 8'h80;
        load_mode = 1'b1;
        step();
        wait_ready("mid load_ready");
        feed(4'h1, 0);
        feed(4'h2, 0);
        feed(4'h3, 0);
        check("mid count 3", 32'(load_count), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid rst load_ready", 32'(load_ready), 32'd0);
        check("mid rst load_count", 32'(load_count), 32'd0);
        check("mid rst cpu_reset", 32'(cpu_reset), 32'd1);
        wait_ready("reload ready");
        check("reload count 0", 32'(load_count), 32'd0);
        feed(4'h9, 0);
        load_valid = 1'b1;
        load_data  = 4'h6;
        load_mode  = 1'b0;
        step();
        load_valid = 1'b0;
        #1;
        check("last nibble taken", 32'(load_count), 32'd2);
        check("reload exit ready", 32'(load_ready), 32'd0);
        wait_run("reload run");
        step();
        cpu_out = 8'h70;
        #1;
        check("reload code0", 32'(cpu_in_hi[3:0]), 32'h9);
        step();
        check("reload code1", 32'(cpu_in_hi[3:0]), 32'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
